divider_controller: RTL and testbench
=====================================

// Module: divider_controller
// PURPOSE
// Control unit for the 6-bit restoring divider datapath (A, Q and Divisor registers, 7-bit subtractor, A-input mux).
// Accepts a start request and schedules the operand loads onto the shared In_bus.
// Runs N shift/test iterations and reports done / divide-by-zero.
// The divider top level instantiates it next to the datapath; its control outputs wire 1:1 to the datapath load/shift/select inputs.
// PARAMETERS
// N      6   operand width; number of iterations; must match datapath width
// CNT_W  3   iteration counter width, >= clog2(N+1)
// PORTS
// clk                in   1      rising-edge clock
// rst                in   1      synchronous, active-low reset
// start              in   1      request; sampled only in IDLE
// sub_out_sign_bit   in   1      sign of (A - Divisor) from datapath; 0 = A >= Divisor
// in_bus_zero        in   1      top-level flag: current In_bus value == 0
// Ald                out  1      A register parallel load
// Ash                out  1      A register shift left (serial-in = Q MSB)
// Qld                out  1      Q register parallel load
// Qsh                out  1      Q register shift left (serial-in = ~sub_out_sign_bit)
// Divisor_ld         out  1      Divisor register load
// mux_sel            out  1      A input select: 0 = subtractor out, 1 = {0,In_bus}
// in_sel             out  2      In_bus source select to top: 00 zero, 01 dividend, 10 divisor
// ready              out  1      1 in IDLE only
// busy               out  1      1 in any state other than IDLE/DONE
// done               out  1      one-cycle pulse in DONE
// div_by_zero        out  1      registered; set on zero divisor, cleared when the next start is accepted
// BEHAVIOUR
// - Reset (rst=0 at edge): state <= IDLE, count <= 0, div_by_zero <= 0.
//   Outputs after reset: all strobes 0, in_sel=00, ready=1, busy=0, done=0. Reset mid-operation aborts with no done pulse.
// - Strobes are Moore decodes of state; the only exception is Ald in TEST, which depends on sub_out_sign_bit.
// - States and transitions:
//   IDLE   : ready=1. start=1 -> LD_DVD, clear div_by_zero; otherwise stay.
//   LD_DVD : in_sel=01, Qld=1 -> LD_DVS
//   LD_DVS : in_sel=10, Divisor_ld=1
//            in_bus_zero=1 -> DONE, set div_by_zero
//            otherwise -> LD_A
//   LD_A   : in_sel=00, mux_sel=1, Ald=1 (A <= 0); count <= 0 -> SHIFT
//   SHIFT  : Ash=1 only (A <= {A[5:0],Q[5]}; Q held) -> TEST
//   TEST   : Qsh=1 always (Q <= {Q[4:0],~sign}); mux_sel=0; Ald = ~sub_out_sign_bit (restore = no load)
//            count <= count+1; count==N-1 -> DONE, else -> SHIFT
//   DONE   : done=1 -> IDLE. Quotient/Remainder are valid from this cycle until the next LD_DVD.
// - Latency: start sampled at edge t -> done high in cycle t+3+2N+1 (16 cycles for N=6).
//   Divide-by-zero path: done at t+3.
// - start while not in IDLE is ignored (no queueing). start held high through DONE restarts on the cycle after DONE.
// - Never assert Ald with Ash, or Qld with Qsh, in the same cycle.
// - Divide-by-zero: Quotient/Remainder are undefined; div_by_zero stays 1 until the next accepted start.
// STRUCTURE
// - Shared include divider_defs.vh: state encodings (IDLE..DONE, 3-bit), in_sel codes (SEL_ZERO/SEL_DVD/SEL_DVS), default N.
// - One sub-module: divider_iter_counter. Synchronous clear + increment, with terminal flag (count==N-1).
// - Controller body: state register, next-state logic, output decode.
// TESTING
// - 13/4: start, bus 13, 4, 0 -> done at +16, Quotient=3, Remainder=1, div_by_zero=0.
// - 63/1 -> Q=63, R=0. 5/7 -> Q=0, R=5. 42/6 -> Q=7, R=0. Strobe trace matches table.
// - Divisor 0 at LD_DVS -> done at +3, div_by_zero=1, no SHIFT/TEST; cleared on next start.
// - start pulsed during TEST -> ignored; exactly one done; ready low until IDLE.
// - rst=0 during 3rd TEST -> next cycle IDLE, all strobes 0, no done; a fresh 13/4 then gives 3 r1.
// - start held high: back-to-back 13/4 then 9/2 -> done pulses 17 cycles apart; 3 r1 then 4 r1.

Source files
------------

// File: rtl/divider_controller_pkg.sv
// rtl/divider_controller_pkg.sv - shared constants and strobe decode for the restoring divider controller
package divider_controller_pkg;

  localparam int N_DEF     = 6;
  localparam int CNT_W_DEF = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD_DVD = 3'd1;
  localparam logic [2:0] S_LD_DVS = 3'd2;
  localparam logic [2:0] S_LD_A   = 3'd3;
  localparam logic [2:0] S_SHIFT  = 3'd4;
  localparam logic [2:0] S_TEST   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_DVD  = 2'b01;
  localparam logic [1:0] SEL_DVS  = 2'b10;

  typedef struct packed {
    logic       ald;
    logic       ash;
    logic       qld;
    logic       qsh;
    logic       dvs_ld;
    logic       mux_sel;
    logic [1:0] in_sel;
  } ctrl_t;

  // Datapath strobes are a pure decode of state; only Ald in TEST looks at the
  // subtractor sign (load the difference when A >= Divisor, else restore by not loading).
  function automatic ctrl_t ctrl_decode(input logic [2:0] state, input logic sign);
    ctrl_t c;
    c = '0;
    case (state)
      S_LD_DVD: begin
        c.in_sel = SEL_DVD;
        c.qld    = 1'b1;
      end
      S_LD_DVS: begin
        c.in_sel = SEL_DVS;
        c.dvs_ld = 1'b1;
      end
      S_LD_A: begin
        c.in_sel  = SEL_ZERO;
        c.mux_sel = 1'b1;
        c.ald     = 1'b1;
      end
      S_SHIFT: begin
        c.ash = 1'b1;
      end
      S_TEST: begin
        c.qsh     = 1'b1;
        c.mux_sel = 1'b0;
        c.ald     = ~sign;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/divider_iter_counter.sv
// rtl/divider_iter_counter.sv - iteration counter with clear, increment and terminal flag
module divider_iter_counter
  import divider_controller_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_terminal
);

  logic [CNT_W-1:0] r_count;

  // Clear has priority over increment; reset is synchronous active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == CNT_W'(N - 1));

endmodule

// File: rtl/divider_controller.sv
// rtl/divider_controller.sv - control FSM for the 6-bit restoring divider datapath
module divider_controller
  import divider_controller_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sub_out_sign_bit,
  input  logic       in_bus_zero,
  output logic       Ald,
  output logic       Ash,
  output logic       Qld,
  output logic       Qsh,
  output logic       Divisor_ld,
  output logic       mux_sel,
  output logic [1:0] in_sel,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_dbz;
  logic       w_term;
  ctrl_t      w_ctrl;

  divider_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == S_LD_A),
    .i_inc      (r_state == S_TEST),
    .o_terminal (w_term)
  );

  // Next-state selection; start is only looked at in IDLE so requests while busy are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LD_DVD;
      S_LD_DVD: w_next = S_LD_DVS;
      S_LD_DVS: w_next = in_bus_zero ? S_DONE : S_LD_A;
      S_LD_A:   w_next = S_SHIFT;
      S_SHIFT:  w_next = S_TEST;
      S_TEST:   w_next = w_term ? S_DONE : S_SHIFT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register; reset mid-operation simply drops back to IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Divide-by-zero flag: raised when the divisor on the bus is zero, held until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbz <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_dbz <= 1'b0;
    end else if (r_state == S_LD_DVS && in_bus_zero) begin
      r_dbz <= 1'b1;
    end
  end

  assign w_ctrl      = ctrl_decode(r_state, sub_out_sign_bit);
  assign Ald         = w_ctrl.ald;
  assign Ash         = w_ctrl.ash;
  assign Qld         = w_ctrl.qld;
  assign Qsh         = w_ctrl.qsh;
  assign Divisor_ld  = w_ctrl.dvs_ld;
  assign mux_sel     = w_ctrl.mux_sel;
  assign in_sel      = w_ctrl.in_sel;
  assign ready       = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_controller.sv
// tb/tb_divider_controller.sv - randomized self-checking bench with a behavioural divider datapath
module tb_divider_controller;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sub_out_sign_bit;
  logic       in_bus_zero;
  logic       Ald, Ash, Qld, Qsh, Divisor_ld, mux_sel;
  logic [1:0] in_sel;
  logic       ready, busy, done, div_by_zero;

  logic [5:0] dvd = 6'd0;
  logic [5:0] dvs = 6'd0;
  logic [6:0] m_a = 7'd0;
  logic [5:0] m_q = 6'd0;
  logic [5:0] m_d = 6'd0;
  logic [5:0] w_bus;
  logic [6:0] w_sub;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_controller #(.N(N), .CNT_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .sub_out_sign_bit (sub_out_sign_bit),
    .in_bus_zero      (in_bus_zero),
    .Ald              (Ald),
    .Ash              (Ash),
    .Qld              (Qld),
    .Qsh              (Qsh),
    .Divisor_ld       (Divisor_ld),
    .mux_sel          (mux_sel),
    .in_sel           (in_sel),
    .ready            (ready),
    .busy             (busy),
    .done             (done),
    .div_by_zero      (div_by_zero)
  );

  // Behavioural datapath: A (7b), Q, Divisor, subtractor and In_bus mux driven by the strobes.
  assign w_bus            = (in_sel == 2'b01) ? dvd : (in_sel == 2'b10) ? dvs : 6'd0;
  assign in_bus_zero      = (w_bus == 6'd0);
  assign w_sub            = m_a - {1'b0, m_d};
  assign sub_out_sign_bit = w_sub[6];

  always @(posedge clk) begin
    if (Ald)      m_a <= mux_sel ? {1'b0, w_bus} : w_sub;
    else if (Ash) m_a <= {m_a[5:0], m_q[5]};
    if (Qld)      m_q <= w_bus;
    else if (Qsh) m_q <= {m_q[4:0], ~w_sub[6]};
    if (Divisor_ld) m_d <= w_bus;
  end

  function automatic logic [7:0] strobes();
    return {Ald, Ash, Qld, Qsh, Divisor_ld, mux_sel, in_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One division from IDLE; reference results come from plain / and %.
  task automatic run_div(input int a, input int b, input bit trace, input bit pulse_mid);
    int lat, ash_cnt, overlap, ready_bad, extra_done;
    logic [7:0] trace_exp [1:4];
    trace_exp[1] = 8'b0010_0001;
    trace_exp[2] = 8'b0000_1010;
    trace_exp[3] = 8'b1000_0100;
    trace_exp[4] = 8'b0100_0000;
    lat = 0; ash_cnt = 0; overlap = 0; ready_bad = 0; extra_done = 0;
    @(negedge clk);
    dvd = a[5:0];
    dvs = b[5:0];
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("dbz_cleared_on_start", div_by_zero, 0);
      end
      if (pulse_mid && k == 9) start = 1'b1;
      if (pulse_mid && k == 10) start = 1'b0;
      if (trace && k <= 4) chk($sformatf("trace_k%0d", k), strobes(), trace_exp[k]);
      if (Ash) ash_cnt++;
      if ((Ald && Ash) || (Qld && Qsh)) overlap++;
      if (!done && ready) ready_bad++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("latency %0d/%0d", a, b), lat, (b == 0) ? 3 : 16);
    chk($sformatf("shift_count %0d/%0d", a, b), ash_cnt, (b == 0) ? 0 : N);
    chk("strobe_overlap", overlap, 0);
    chk("ready_while_busy", ready_bad, 0);
    chk($sformatf("div_by_zero %0d/%0d", a, b), div_by_zero, (b == 0) ? 1 : 0);
    if (b != 0) begin
      chk($sformatf("quotient %0d/%0d", a, b), m_q, a / b);
      chk($sformatf("remainder %0d/%0d", a, b), m_a[5:0], a % b);
    end
    if (pulse_mid) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      chk("ignored_start_no_extra_done", extra_done, 0);
      chk("ignored_start_ready", ready, 1);
    end
  endtask

  initial begin
    int a, b, t_first, t_second, tcnt, extra;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", strobes(), 0);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst = 1'b1;

    run_div(13, 4, 1'b1, 1'b0);
    run_div(63, 1, 1'b0, 1'b0);
    run_div(5, 7, 1'b0, 1'b0);
    run_div(42, 6, 1'b0, 1'b0);
    run_div(17, 0, 1'b0, 1'b0);
    run_div(9, 2, 1'b0, 1'b1);

    // Reset during the third TEST cycle aborts without a done pulse.
    @(negedge clk);
    dvd = 6'd13; dvs = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tcnt = 0;
    for (int k = 0; k < 40 && tcnt < 3; k++) begin
      @(negedge clk);
      if (Qsh) tcnt++;
    end
    chk("found_third_test", tcnt, 3);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_strobes", strobes(), 0);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);
    run_div(13, 4, 1'b0, 1'b0);

    // start held high: two operations back to back.
    @(negedge clk);
    dvd = 6'd13; dvs = 6'd4; start = 1'b1;
    t_first = 0; t_second = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done && t_first == 0) begin
        t_first = k;
        chk("b2b_q1", m_q, 3);
        chk("b2b_r1", m_a[5:0], 1);
        dvd = 6'd9; dvs = 6'd2;
      end else if (done) begin
        t_second = k;
        chk("b2b_q2", m_q, 4);
        chk("b2b_r2", m_a[5:0], 1);
        break;
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", t_first, 16);
    chk("b2b_gap", t_second - t_first, 17);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 63);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      run_div(a, b, 1'b0, (i % 8) == 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
